// File: rtl/decode_stage.sv
// RV32I/M decode pipeline stage: registered {pc, decoded fields} between fetch and execute,
// valid/ready on both sides, flush kills held and incoming bundles, and a saturating counter
// tracks accepted illegal instructions.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter bit          EN_M  = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    input  logic             flush,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [6:0]       id_opcode,
    output logic [2:0]       id_func3,
    output logic [6:0]       id_func7,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic [4:0]       id_rd,
    output logic [XLEN-1:0]  id_imm,
    output logic             id_rs1_en,
    output logic             id_rs2_en,
    output logic             id_rd_we,
    output logic             id_illegal,
    output logic [CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            use_rs1, use_rs2, use_rd;
    logic [31:0]     imm32;
    logic [2:0]      dec_func3;
    logic [6:0]      dec_func7;
    logic            dec_illegal;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_rs1_en, dec_rs2_en, dec_rd_we;
    logic [XLEN-1:0] dec_imm;
    logic            capture;

    assign opcode = if_inst[6:0];
    assign f3     = if_inst[14:12];
    assign f7     = if_inst[31:25];

    // Field usage, immediate format and legality per opcode; every opcode has a defined result.
    always_comb begin
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        use_rd      = 1'b0;
        imm32       = 32'h0;
        dec_func3   = 3'b000;
        dec_func7   = 7'b0000000;
        dec_illegal = 1'b0;
        // All nine opcodes end in 2'b11, so a low-bit mismatch always lands in default.
        case (opcode)
            OpLui, OpAuipc: begin
                use_rd = 1'b1;
                imm32  = {if_inst[31:12], 12'b0};
            end
            OpJal: begin
                use_rd = 1'b1;
                imm32  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                          if_inst[30:21], 1'b0};
            end
            OpJalr: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec_func3   = f3;
                imm32       = {{20{if_inst[31]}}, if_inst[31:20]};
                dec_illegal = (f3 != 3'b000);
            end
            OpBranch: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec_func3   = f3;
                imm32       = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                               if_inst[11:8], 1'b0};
                dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OpLoad: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec_func3   = f3;
                imm32       = {{20{if_inst[31]}}, if_inst[31:20]};
                dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OpStore: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec_func3   = f3;
                imm32       = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
                dec_illegal = (f3 > 3'b010);
            end
            OpImm: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                dec_func3   = f3;
                dec_func7   = f7;
                imm32       = {{20{if_inst[31]}}, if_inst[31:20]};
                // Shift-immediates carry func7 in the upper immediate bits.
                dec_illegal = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                              ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
            end
            OpReg: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                use_rd      = 1'b1;
                dec_func3   = f3;
                dec_func7   = f7;
                dec_illegal = !((f7 == 7'b0000000) ||
                                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                                ((f7 == 7'b0000001) && EN_M));
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_rs1    = use_rs1 ? if_inst[19:15] : 5'd0;
    assign dec_rs2    = use_rs2 ? if_inst[24:20] : 5'd0;
    assign dec_rd     = use_rd  ? if_inst[11:7]  : 5'd0;
    assign dec_rs1_en = use_rs1 && !dec_illegal;
    assign dec_rs2_en = use_rs2 && !dec_illegal;
    assign dec_rd_we  = use_rd && (dec_rd != 5'd0) && !dec_illegal;
    assign dec_imm    = XLEN'($signed(imm32));

    assign if_ready = !id_valid || id_ready;
    assign capture  = if_valid && if_ready && !flush;

    // Output bundle register: load on capture, drop valid on handoff or flush, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_opcode  <= '0;
            id_func3   <= '0;
            id_func7   <= '0;
            id_rs1     <= '0;
            id_rs2     <= '0;
            id_rd      <= '0;
            id_imm     <= '0;
            id_rs1_en  <= 1'b0;
            id_rs2_en  <= 1'b0;
            id_rd_we   <= 1'b0;
            id_illegal <= 1'b0;
        end else if (capture) begin
            id_valid   <= 1'b1;
            id_pc      <= if_pc;
            id_opcode  <= opcode;
            id_func3   <= dec_func3;
            id_func7   <= dec_func7;
            id_rs1     <= dec_rs1;
            id_rs2     <= dec_rs2;
            id_rd      <= dec_rd;
            id_imm     <= dec_imm;
            id_rs1_en  <= dec_rs1_en;
            id_rs2_en  <= dec_rs2_en;
            id_rd_we   <= dec_rd_we;
            id_illegal <= dec_illegal;
        end else if (flush || (id_valid && id_ready)) begin
            id_valid <= 1'b0;
        end
    end

    // Saturating count of illegal instructions actually accepted (flushed ones don't count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (capture && dec_illegal && (ill_cnt != {CNT_W{1'b1}})) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

endmodule
